// File: rtl/pwm_fader_pkg.sv
// pwm_fader_pkg: types shared by the pwm_fader ramp generator and its prescaler.
//   fade_state_e : ramp state (hold / ramping up / ramping down)
//   fade_mode_e  : cfg_mode decode (fade to target / breathe between 0 and target)
package pwm_fader_pkg;

    typedef enum logic [1:0] {
        StHold = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } fade_state_e;

    typedef enum logic {
        ModeFade    = 1'b0,
        ModeBreathe = 1'b1
    } fade_mode_e;

endpackage

// File: rtl/pwm_fader_tick.sv
// pwm_fader_tick: prescaler producing a one-cycle tick every cfg_div+1 cycles.
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   cfg_en  in   enable; low clears the counter so the first tick follows immediately
//   cfg_div in   tick period minus 1
//   tick    out  asserted while enabled and the counter is zero
module pwm_fader_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    assign tick = cfg_en && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (!cfg_en) begin
            count_d = '0;
        end else if (tick) begin
            count_d = cfg_div;
        end else begin
            count_d = count_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: brightness ramp generator feeding a PWM duty input.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   cfg_en     in   enable; low freezes out_val and clears the prescaler
//   cfg_mode   in   0 = fade to target, 1 = breathe between 0 and target
//   cfg_target in   target / peak level
//   cfg_step   in   increment per tick (0 behaves as 1)
//   cfg_div    in   tick period minus 1, in clk cycles
//   out_val    out  current level
//   out_stb    out  one-cycle pulse after out_val changed
//   busy       out  ramp in progress (state != hold)
//   done       out  one-cycle pulse when a fade step lands on the target
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic                 cfg_mode,
    input  logic [WIDTH-1:0]     cfg_target,
    input  logic [WIDTH-1:0]     cfg_step,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic [WIDTH-1:0]     out_val,
    output logic                 out_stb,
    output logic                 busy,
    output logic                 done
);

    logic tick;

    pwm_fader_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .cfg_en  (cfg_en),
        .cfg_div (cfg_div),
        .tick    (tick)
    );

    fade_state_e      state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;

    // Saturation tests run one bit wider so neither the gaps nor the step can wrap.
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   val_x;
    logic [WIDTH:0]   up_gap;
    logic [WIDTH:0]   dn_gap;

    always_comb begin
        step_eff = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
        step_x   = {1'b0, step_eff};
        val_x    = {1'b0, val_q};
        up_gap   = {1'b0, cfg_target} - val_x;
        dn_gap   = val_x - {1'b0, cfg_target};
    end

    always_comb begin
        val_d   = val_q;
        state_d = state_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;

        if (tick) begin
            if (fade_mode_e'(cfg_mode) == ModeFade) begin
                if (val_q < cfg_target) begin
                    if (up_gap <= step_x) begin
                        val_d   = cfg_target;
                        state_d = StHold;
                        done_d  = 1'b1;
                    end else begin
                        val_d   = val_q + step_eff;
                        state_d = StUp;
                    end
                end else if (val_q > cfg_target) begin
                    if (dn_gap <= step_x) begin
                        val_d   = cfg_target;
                        state_d = StHold;
                        done_d  = 1'b1;
                    end else begin
                        val_d   = val_q - step_eff;
                        state_d = StDown;
                    end
                end else begin
                    state_d = StHold;
                end
            end else begin
                if (cfg_target == '0) begin
                    val_d   = '0;
                    state_d = StHold;
                end else if (state_q == StDown || val_q >= cfg_target) begin
                    // Descending leg; also entered when the peak was lowered below out_val
                    // or when breathe starts sitting exactly on the peak.
                    if (val_x <= step_x) begin
                        val_d   = '0;
                        state_d = StUp;
                    end else begin
                        val_d   = val_q - step_eff;
                        state_d = StDown;
                    end
                end else begin
                    if (up_gap <= step_x) begin
                        val_d   = cfg_target;
                        state_d = StDown;
                    end else begin
                        val_d   = val_q + step_eff;
                        state_d = StUp;
                    end
                end
            end
            stb_d = (val_d != val_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            val_q   <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
        end
    end

    assign out_val = val_q;
    assign out_stb = stb_q;
    assign done    = done_q;
    assign busy    = (state_q != StHold);

endmodule
